// File: rtl/proc_program_sequencer_if.sv
// ROM and processor-side bus for the program sequencer.
// Master is the sequencer; slave is the ROM/processor pair.
interface proc_program_sequencer_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       proc_din;
  logic              proc_run;
  logic              proc_done;

  modport master (
    output rom_addr, proc_din, proc_run,
    input  rom_data, proc_done
  );

  modport slave (
    input  rom_addr, proc_din, proc_run,
    output rom_data, proc_done
  );
endinterface

// File: rtl/proc_program_sequencer.sv
// Autonomous instruction feeder: fetches words from a synchronous ROM, issues them
// (plus the mvi immediate) to the register-bank processor and waits for done.
module proc_program_sequencer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 7
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       step_mode,
  input  logic                       step,
  proc_program_sequencer_if.master   bus,
  output logic [ADDR_W-1:0]          pc,
  output logic                       busy,
  output logic                       halted,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [7:0]                 instr_count
);

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_FETCH_IMM = 4'd3;
  localparam logic [3:0] S_IMM_LATCH = 4'd4;
  localparam logic [3:0] S_ISSUE     = 4'd5;
  localparam logic [3:0] S_WAIT_DONE = 4'd6;
  localparam logic [3:0] S_STEP_WAIT = 4'd7;
  localparam logic [3:0] S_HALTED    = 4'd8;
  localparam logic [3:0] S_ERROR     = 4'd9;

  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_NO_IMM  = 2'd3;

  logic [3:0]        state_q,       state_d;
  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic [ADDR_W-1:0] rom_addr_q,    rom_addr_d;
  logic [15:0]       instr_q,       instr_d;
  logic [15:0]       imm_q,         imm_d;
  logic [15:0]       proc_din_q,    proc_din_d;
  logic              proc_run_q,    proc_run_d;
  logic [CNT_W-1:0]  tmo_q,         tmo_d;
  logic [1:0]        err_code_q,    err_code_d;
  logic [7:0]        instr_count_q, instr_count_d;
  logic              busy_q,        busy_d;
  logic              halted_q,      halted_d;
  logic              error_q,       error_d;

  logic pc_last_c;
  assign pc_last_c = (pc_q == {ADDR_W{1'b1}});

  // Next-state logic; registered outputs are derived from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imm_d         = imm_q;
    tmo_d         = tmo_q;
    err_code_d    = err_code_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d       = S_FETCH;
          pc_d          = '0;
          err_code_d    = ERR_NONE;
          instr_count_d = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = bus.rom_data;
        case (bus.rom_data[15:13])
          OP_HALT: state_d = S_HALTED;
          3'd4, 3'd5, 3'd6: begin
            state_d    = S_ERROR;
            err_code_d = ERR_ILLEGAL;
          end
          OP_MVI: begin
            if (pc_last_c) begin
              state_d    = S_ERROR;
              err_code_d = ERR_NO_IMM;
            end else begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = S_FETCH_IMM;
            end
          end
          default: state_d = S_ISSUE;
        endcase
      end
      S_FETCH_IMM: state_d = S_IMM_LATCH;
      S_IMM_LATCH: begin
        imm_d   = bus.rom_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done takes priority over an expiring timeout in the same cycle
        if (bus.proc_done) begin
          if (instr_count_q != 8'hFF) instr_count_d = instr_count_q + 8'd1;
          if (pc_last_c) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = step_mode ? S_STEP_WAIT : S_FETCH;
          end
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
          if (tmo_d == CNT_W'(TIMEOUT)) begin
            state_d    = S_ERROR;
            err_code_d = ERR_TIMEOUT;
          end
        end
      end
      S_STEP_WAIT: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    rom_addr_d = pc_d;
    proc_run_d = (state_d == S_ISSUE);

    proc_din_d = proc_din_q;
    if (state_d == S_IDLE) begin
      proc_din_d = '0;
    end else if (state_d == S_ISSUE) begin
      proc_din_d = instr_d;
    end else if (state_d == S_WAIT_DONE) begin
      proc_din_d = (instr_d[15:13] == OP_MVI) ? imm_d : instr_d;
    end

    busy_d   = !((state_d == S_IDLE) || (state_d == S_HALTED) || (state_d == S_ERROR));
    halted_d = (state_d == S_HALTED);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      rom_addr_q    <= '0;
      instr_q       <= '0;
      imm_q         <= '0;
      proc_din_q    <= '0;
      proc_run_q    <= 1'b0;
      tmo_q         <= '0;
      err_code_q    <= ERR_NONE;
      instr_count_q <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_addr_q    <= rom_addr_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      proc_din_q    <= proc_din_d;
      proc_run_q    <= proc_run_d;
      tmo_q         <= tmo_d;
      err_code_q    <= err_code_d;
      instr_count_q <= instr_count_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      error_q       <= error_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.proc_din = proc_din_q;
  assign bus.proc_run = proc_run_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_proc_program_sequencer.sv
// Directed bench for proc_program_sequencer with a behavioural ROM and a
// processor stub that raises done a fixed number of cycles after run.
module tb_proc_program_sequencer;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned TIMEOUT = 7;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              step_mode = 1'b0;
  logic              step = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              busy, halted, error;
  logic [1:0]        err_code;
  logic [7:0]        instr_count;

  proc_program_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  proc_program_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .bus         (bus),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  logic [15:0] rom [32];
  always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  // Processor stub: done pulses done_dly cycles after the run strobe.
  int   done_dly = 2;
  logic done_en = 1'b1;
  logic done_force = 1'b0;
  logic done_model = 1'b0;
  int   dcnt = 0;
  always @(posedge clock) begin
    done_model <= 1'b0;
    if (!resetn) begin
      dcnt <= 0;
    end else if (bus.proc_run && done_en) begin
      if (done_dly == 1) done_model <= 1'b1;
      else dcnt <= done_dly - 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) done_model <= 1'b1;
    end
  end
  assign bus.proc_done = done_model | done_force;

  int cyc = 0;
  int run_cnt = 0;
  int last_run_cyc = 0;
  int prev_run_cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.proc_run) begin
      run_cnt      <= run_cnt + 1;
      prev_run_cyc <= last_run_cyc;
      last_run_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
  endtask

  // Returns at the negedge of the next ISSUE cycle.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!bus.proc_run && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.proc_run) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_stop(input string tag);
    int n;
    n = 0;
    while (!(halted || error) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!(halted || error)) check(tag, 32'd0, 32'd1);
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  int base;

  initial begin
    fill_rom(16'hE000);
    do_reset();
    @(negedge clock);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_pc",     32'(pc), 32'd0);
    check("rst_din",    32'(bus.proc_din), 32'd0);
    check("rst_flags",  {29'd0, halted, error, bus.proc_run}, 32'd0);

    // mvi R0,5 ; mv R1,R0 ; HALT
    rom[0] = 16'h2000; rom[1] = 16'h0005; rom[2] = 16'h0080; rom[3] = 16'hE000;
    done_dly = 2;
    base = run_cnt;
    pulse_start();
    wait_run("t1_run0");
    check("t1_issue_din", 32'(bus.proc_din), 32'h2000);
    @(negedge clock);
    check("t1_wait_din", 32'(bus.proc_din), 32'h0005);
    check("t1_run_low",  32'(bus.proc_run), 32'd0);
    wait_stop("t1_stop");
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_pc",     32'(pc), 32'd3);
    check("t1_count",  32'(instr_count), 32'd2);
    check("t1_runs",   32'(run_cnt - base), 32'd2);
    check("t1_lat_mv", 32'(last_run_cyc - prev_run_cyc), 32'd5);
    check("t1_busy",   32'(busy), 32'd0);

    // illegal opcode at pc 0
    fill_rom(16'hE000);
    rom[0] = 16'h8000;
    base = run_cnt;
    pulse_start();
    wait_stop("t2_stop");
    check("t2_error", 32'(error), 32'd1);
    check("t2_code",  32'(err_code), 32'd1);
    check("t2_pc",    32'(pc), 32'd0);
    check("t2_runs",  32'(run_cnt - base), 32'd0);

    // done timeout on add
    rom[0] = 16'h4000;
    done_en = 1'b0;
    pulse_start();
    wait_run("t3_run");
    repeat (TIMEOUT) @(negedge clock);
    check("t3_err_early", 32'(error), 32'd0);
    check("t3_busy_early", 32'(busy), 32'd1);
    @(negedge clock);
    check("t3_err",  32'(error), 32'd1);
    check("t3_code", 32'(err_code), 32'd2);
    check("t3_busy", 32'(busy), 32'd0);
    done_en = 1'b1;

    // single-step: three mv then HALT
    fill_rom(16'hE000);
    rom[0] = 16'h0080; rom[1] = 16'h0080; rom[2] = 16'h0080;
    step_mode = 1'b1;
    base = run_cnt;
    pulse_start();
    wait_run("t4_run0");
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    repeat (10) @(negedge clock);
    check("t4_runs1", 32'(run_cnt - base), 32'd1);
    check("t4_pc1",   32'(pc), 32'd1);
    check("t4_busy1", 32'(busy), 32'd1);
    pulse_step();
    repeat (10) @(negedge clock);
    check("t4_runs2", 32'(run_cnt - base), 32'd2);
    pulse_step();
    repeat (10) @(negedge clock);
    check("t4_runs3", 32'(run_cnt - base), 32'd3);
    check("t4_halt_early", 32'(halted), 32'd0);
    pulse_step();
    wait_stop("t4_stop");
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_pc",     32'(pc), 32'd3);
    check("t4_count",  32'(instr_count), 32'd3);
    step_mode = 1'b0;

    // mvi on the last word
    fill_rom(16'h0080);
    rom[31] = 16'h2000;
    done_dly = 1;
    pulse_start();
    wait_stop("t5_stop");
    check("t5_error", 32'(error), 32'd1);
    check("t5_code",  32'(err_code), 32'd3);
    check("t5_pc",    32'(pc), 32'd31);
    check("t5_count", 32'(instr_count), 32'd31);
    pulse_start();
    check("t5_re_code",  32'(err_code), 32'd0);
    check("t5_re_count", 32'(instr_count), 32'd0);
    check("t5_re_pc",    32'(pc), 32'd0);
    check("t5_re_busy",  32'(busy), 32'd1);

    // reset in the middle of WAIT_DONE, then a late done
    do_reset();
    fill_rom(16'hE000);
    rom[0] = 16'h4000;
    done_en = 1'b0;
    pulse_start();
    wait_run("t6_run");
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    done_force = 1'b1;
    base = run_cnt;
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_pc",    32'(pc), 32'd0);
    check("t6_din",   32'(bus.proc_din), 32'd0);
    check("t6_flags", {28'd0, err_code, halted, error}, 32'd0);
    @(negedge clock);
    done_force = 1'b0;
    repeat (4) @(negedge clock);
    check("t6_count", 32'(instr_count), 32'd0);
    check("t6_idle",  32'(busy), 32'd0);
    check("t6_runs",  32'(run_cnt - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
